// File: rtl/idct_pkg.sv
// Shared constants, FSM state type, cosine table and output saturation for idct8_serial.
// Build option IDCT_LEVEL_SHIFT_EN: emit unsigned level-shifted pixels instead of signed samples.

package idct_pkg;

  localparam int COEF_W    = 8;
  localparam int FRAC_W    = 12;
  localparam int ACC_W     = 24;
  localparam int ROM_W     = 13;
  localparam int ROUND_K   = 2048;
  localparam int LEVEL_OFS = 128;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    MAC  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // COS_ROM[{k,u}] = round(4096 * c(u)/2 * cos((2k+1)*u*pi/16)), c(0) = 1/sqrt(2)
  localparam logic signed [ROM_W-1:0] COS_ROM [64] = '{
    13'sd1448,  13'sd2009,  13'sd1892,  13'sd1703,  13'sd1448,  13'sd1138,  13'sd784,   13'sd400,
    13'sd1448,  13'sd1703,  13'sd784,  -13'sd400,  -13'sd1448, -13'sd2009, -13'sd1892, -13'sd1138,
    13'sd1448,  13'sd1138, -13'sd784,  -13'sd2009, -13'sd1448,  13'sd400,   13'sd1892,  13'sd1703,
    13'sd1448,  13'sd400,  -13'sd1892, -13'sd1138,  13'sd1448,  13'sd1703, -13'sd784,  -13'sd2009,
    13'sd1448, -13'sd400,  -13'sd1892,  13'sd1138,  13'sd1448, -13'sd1703, -13'sd784,   13'sd2009,
    13'sd1448, -13'sd1138, -13'sd784,   13'sd2009, -13'sd1448, -13'sd400,   13'sd1892, -13'sd1703,
    13'sd1448, -13'sd1703,  13'sd784,   13'sd400,  -13'sd1448,  13'sd2009, -13'sd1892,  13'sd1138,
    13'sd1448, -13'sd2009,  13'sd1892, -13'sd1703,  13'sd1448, -13'sd1138,  13'sd784,  -13'sd400
  };

  // Round the Q12 accumulator to an integer sample and clamp it to the 8-bit output range.
  function automatic logic [7:0] pix_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] r;
    logic signed [ACC_W-1:0] lo;
    logic signed [ACC_W-1:0] hi;
    r = (acc + ACC_W'(ROUND_K)) >>> FRAC_W;
`ifdef IDCT_LEVEL_SHIFT_EN
    r  = r + ACC_W'(LEVEL_OFS);
    lo = '0;
    hi = ACC_W'(2 * LEVEL_OFS - 1);
`else
    lo = ACC_W'(-LEVEL_OFS);
    hi = ACC_W'(LEVEL_OFS - 1);
`endif
    if (r < lo) r = lo;
    else if (r > hi) r = hi;
    return r[7:0];
  endfunction

endpackage

// File: rtl/idct8_serial_rom.sv
// Combinational cosine constant lookup addressed by {k,u}.

module idct_cos_rom
  import idct_pkg::*;
(
  input  logic        [5:0]       addr_i,
  output logic signed [ROM_W-1:0] coef_o
);

  assign coef_o = COS_ROM[addr_i];

endmodule

// File: rtl/idct8_serial.sv
// Serial 8-point 1-D IDCT: loads 8 coefficients, runs 8 MAC cycles per output sample.
// Build option IDCT_LEVEL_SHIFT_EN: output pixels are level-shifted to 0..255.

module idct8_serial
  import idct_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_coef,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_pix,
  output logic              out_last,
  output logic [1:0]        dbg_state_o
);

  // Stream handshakes: a beat moves on a rising edge where valid && ready; a source
  // holds valid and data stable until accepted, and ready never depends on valid.

  state_t state_q, state_d;
  logic [2:0] u_q, u_d;
  logic [2:0] k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic [7:0] out_pix_q, out_pix_d;
  logic signed [COEF_W-1:0] coef_buf_q [8];
  logic signed [ROM_W-1:0] rom_val;
  logic signed [ACC_W-1:0] coef_ext, rom_ext, prod;
  logic in_fire, out_fire, buf_we;

  idct_cos_rom u_rom (
    .addr_i ({k_q, u_q}),
    .coef_o (rom_val)
  );

  assign coef_ext = ACC_W'(coef_buf_q[u_q]);
  assign rom_ext  = ACC_W'(rom_val);
  assign prod     = coef_ext * rom_ext;

  assign in_ready    = (state_q == LOAD) && !rst;
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid_q && out_ready;
  assign out_valid   = out_valid_q;
  assign out_pix     = out_pix_q;
  assign out_last    = out_last_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d     = state_q;
    u_d         = u_q;
    k_d         = k_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_pix_d   = out_pix_q;
    buf_we      = 1'b0;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          buf_we = 1'b1;
          u_d    = u_q + 3'd1;
          if (u_q == 3'd7) begin
            state_d = MAC;
            k_d     = 3'd0;
            acc_d   = '0;
          end
        end
      end
      MAC: begin
        acc_d = acc_q + prod;
        u_d   = u_q + 3'd1;
        if (u_q == 3'd7) begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_pix_d   = pix_sat(acc_d);
          out_last_d  = (k_q == 3'd7);
        end
      end
      EMIT: begin
        // Outputs stay frozen until the sample is accepted.
        if (out_fire) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          k_d         = k_q + 3'd1;
          u_d         = 3'd0;
          acc_d       = '0;
          state_d     = (k_q == 3'd7) ? LOAD : MAC;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      u_q         <= 3'd0;
      k_q         <= 3'd0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      u_q         <= u_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // The coefficient buffer is plain storage; a partial row left in it is simply overwritten.
  always_ff @(posedge clk) begin
    if (buf_we) coef_buf_q[u_q] <= in_coef;
  end

endmodule

// File: tb/tb_idct8_serial.sv
// Directed self-checking bench for idct8_serial (DC, zero, saturation, stall, reset, back-to-back).

module tb_idct8_serial;
  import idct_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_coef = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pix;
  logic       out_last;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cnt = 0;
  logic [7:0] exp_q[$];

`ifdef IDCT_LEVEL_SHIFT_EN
  localparam logic [7:0] EXP_DC   = 8'd151;
  localparam logic [7:0] EXP_ZERO = 8'd128;
  localparam logic [7:0] EXP_SAT  = 8'd255;
  localparam logic [7:0] EXP_B [8] = '{8'd159, 8'd155, 8'd146, 8'd134, 8'd122, 8'd110, 8'd101, 8'd97};
`else
  localparam logic [7:0] EXP_DC   = 8'd23;
  localparam logic [7:0] EXP_ZERO = 8'd0;
  localparam logic [7:0] EXP_SAT  = 8'd127;
  localparam logic [7:0] EXP_B [8] = '{8'd31, 8'd27, 8'd18, 8'd6, 8'hFA, 8'hEE, 8'hE5, 8'hE1};
`endif

  localparam logic [63:0] ROW_DC  = 64'h0000_0000_0000_0040;
  localparam logic [63:0] ROW_B   = 64'h0000_0000_0000_4000;
  localparam logic [63:0] ROW_127 = {8{8'h7F}};

  idct8_serial dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_coef     (in_coef),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pix     (out_pix),
    .out_last    (out_last),
    .dbg_state_o (dbg_state)
  );

  // Clock, cycle counter and accepted-coefficient counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Offer n coefficients of row (byte u = X(u)); returns at the negedge of the last accepted beat.
  task automatic load_row(input logic [63:0] row, input int n, output int t_first, output int t_last);
    int u;
    int budget;
    u = 0;
    budget = 0;
    t_first = 0;
    t_last = 0;
    while (u < n && budget < 300) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_coef  = row[8*u +: 8];
      if (in_ready) begin
        if (u == 0) t_first = cyc;
        t_last = cyc;
        u++;
      end
      budget++;
    end
    check("load_count", u, n);
  endtask

  // Collect 8 samples against exp_q; optional stall on sample stall_k for 5 cycles.
  task automatic collect_row(input logic [7:0] mask, input int stall_k, input int t_ref,
                             input int extra, input logic hold_v, input logic [7:0] next_coef,
                             input logic check_rise, output int t_rise);
    int rdy_hi;
    logic [7:0] e;
    rdy_hi = 0;
    t_rise = 0;
    for (int k = 0; k < 8; k++) begin
      int budget;
      budget = 0;
      do begin
        @(negedge clk);
        in_valid = hold_v;
        in_coef  = next_coef;
        budget++;
        if (in_ready) rdy_hi++;
      end while (!out_valid && budget < 40);
      check("out_valid_seen", out_valid, 1);
      if (k == 0) check("first_valid_cycle", cyc, t_ref + 9);
      e = exp_q.pop_front();
      if (mask[k]) check($sformatf("pix_k%0d", k), out_pix, e);
      check($sformatf("last_k%0d", k), out_last, (k == 7));
      if (k == stall_k) begin
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (in_ready) rdy_hi++;
          check("stall_hold", {out_valid, out_pix}, {1'b1, e});
        end
        out_ready = 1'b1;
      end
    end
    check("in_ready_low_mac_emit", rdy_hi, 0);
    if (check_rise) begin
      @(negedge clk);
      in_valid = 1'b0;
      t_rise = cyc;
      check("in_ready_rise", in_ready, 1);
      check("row_end_cycle", cyc, t_ref + 73 + extra);
    end
  endtask

  initial begin
    int tf, tl, tr, tf_b, tl_b, hs0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_state", dbg_state, LOAD);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // DC row of 64
    repeat (8) exp_q.push_back(EXP_DC);
    load_row(ROW_DC, 8, tf, tl);
    collect_row(8'hFF, -1, tl, 0, 1'b0, 8'd0, 1'b1, tr);
    check("dc_row_period", tr - tf, 80);

    // All-zero row
    repeat (8) exp_q.push_back(EXP_ZERO);
    load_row(64'd0, 8, tf, tl);
    collect_row(8'hFF, -1, tl, 0, 1'b0, 8'd0, 1'b1, tr);

    // All 127: x(0) saturates
    exp_q.push_back(EXP_SAT);
    repeat (7) exp_q.push_back(8'd0);
    load_row(ROW_127, 8, tf, tl);
    collect_row(8'h01, -1, tl, 0, 1'b0, 8'd0, 1'b1, tr);

    // DC row with a 5-cycle stall on x(2); in_valid held high through MAC/EMIT
    hs0 = hs_cnt;
    repeat (8) exp_q.push_back(EXP_DC);
    load_row(ROW_DC, 8, tf, tl);
    collect_row(8'hFF, 2, tl, 5, 1'b1, 8'h55, 1'b1, tr);
    check("stall_row_period", tr - tf, 85);
    check("stall_row_consumed", hs_cnt - hs0, 8);

    // Reset during a partial load, then during MAC
    load_row(ROW_127, 4, tf, tl);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("partial_rst_state", dbg_state, LOAD);
    load_row(ROW_127, 8, tf, tl);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_state", dbg_state, MAC);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mac_rst_state", dbg_state, LOAD);
    check("mac_rst_in_ready", in_ready, 1);
    check("mac_rst_out_valid", out_valid, 0);
    check("mac_rst_out_pix", out_pix, 0);
    check("mac_rst_out_last", out_last, 0);
    repeat (8) exp_q.push_back(EXP_DC);
    load_row(ROW_DC, 8, tf, tl);
    collect_row(8'hFF, -1, tl, 0, 1'b0, 8'd0, 1'b1, tr);

    // Back-to-back rows with in_valid held high across the LOAD boundary
    hs0 = hs_cnt;
    repeat (8) exp_q.push_back(EXP_DC);
    load_row(ROW_DC, 8, tf, tl);
    collect_row(8'hFF, -1, tl, 0, 1'b1, ROW_B[7:0], 1'b0, tr);
    check("b2b_row_a_consumed", hs_cnt - hs0, 8);
    for (int k = 0; k < 8; k++) exp_q.push_back(EXP_B[k]);
    load_row(ROW_B, 8, tf_b, tl_b);
    check("b2b_row_b_start", tf_b, tl + 73);
    collect_row(8'hFF, -1, tl_b, 0, 1'b0, 8'd0, 1'b1, tr);
    check("b2b_total_consumed", hs_cnt - hs0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
